// File: rtl/sum_of_squares_if.sv
// rtl/sum_of_squares_if.sv - handshake bundle for the sum_of_squares unit
//
// Signals (slave = the sum_of_squares block, master = the upstream/downstream side):
//   in_valid   master->slave  triple on dx/dy/dz is valid
//   in_ready   slave->master  block can accept a triple
//   dx, dy, dz master->slave  signed D-bit axis differences, D = N/2
//   out_valid  slave->master  sum_sq holds a completed result
//   out_ready  master->slave  consumer accepts the result
//   sum_sq     slave->master  unsigned N-bit dx^2 + dy^2 + dz^2
interface sum_of_squares_if #(
  parameter int N = 32
);
  localparam int D = N / 2;

  logic                in_valid;
  logic                in_ready;
  logic signed [D-1:0] dx;
  logic signed [D-1:0] dy;
  logic signed [D-1:0] dz;
  logic                out_valid;
  logic                out_ready;
  logic [N-1:0]        sum_sq;

  modport slave (
    input  in_valid, dx, dy, dz, out_ready,
    output in_ready, out_valid, sum_sq
  );

  modport master (
    output in_valid, dx, dy, dz, out_ready,
    input  in_ready, out_valid, sum_sq
  );
endinterface

// File: rtl/sum_of_squares.sv
// rtl/sum_of_squares.sv - sequential dx^2+dy^2+dz^2 with one shared shift-add multiplier
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   bus    sum_of_squares_if.slave: in_valid/in_ready/dx/dy/dz in,
//          out_valid/out_ready/sum_sq out
// Each accepted triple takes exactly 3*D cycles in SQ (D bits per axis),
// then the result is held in DONE until the consumer takes it.
module sum_of_squares #(
  parameter int N = 32
) (
  input  logic             clock,
  input  logic             reset,
  sum_of_squares_if.slave  bus
);
  localparam int D  = N / 2;
  localparam int BW = $clog2(D);
  localparam logic [BW-1:0] LAST_BIT = BW'(D - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  acc;
  logic [N-1:0]  mcand;
  logic [D-1:0]  mplier;
  logic [D-1:0]  mag_y;
  logic [D-1:0]  mag_z;
  logic [1:0]    axis;
  logic [BW-1:0] bit_cnt;
  logic          out_valid;
  logic [N-1:0]  sum_sq;
  logic [N-1:0]  acc_next;

  // Magnitude as an unsigned D-bit value; -2^(D-1) negates to the bit
  // pattern 2^(D-1), which is exactly right once read as unsigned.
  function automatic logic [D-1:0] mag_of(input logic [D-1:0] v);
    return v[D-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [N-1:0] zext(input logic [D-1:0] v);
    return {{(N-D){1'b0}}, v};
  endfunction

  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  assign bus.in_ready  = (state == IDLE) && !reset;
  assign bus.out_valid = out_valid;
  assign bus.sum_sq    = sum_sq;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      mag_y     <= '0;
      mag_z     <= '0;
      axis      <= '0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      sum_sq    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is implied here: state is IDLE and reset is low.
          if (bus.in_valid) begin
            mcand   <= zext(mag_of(bus.dx));
            mplier  <= mag_of(bus.dx);
            mag_y   <= mag_of(bus.dy);
            mag_z   <= mag_of(bus.dz);
            acc     <= '0;
            axis    <= '0;
            bit_cnt <= '0;
            state   <= SQ;
          end
        end
        SQ: begin
          acc <= acc_next;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            if (axis == 2'd2) begin
              // acc_next already includes this cycle's final partial product.
              sum_sq    <= acc_next;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              axis   <= axis + 2'd1;
              mcand  <= zext((axis == 2'd0) ? mag_y : mag_z);
              mplier <= (axis == 2'd0) ? mag_y : mag_z;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sum_of_squares.sv
// tb/tb_sum_of_squares.sv - scoreboard bench for sum_of_squares
module tb_sum_of_squares;
  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  logic [31:0] exp_q[$];
  int          acc_q[$];
  logic        prev_ov;
  bit          b2b_mode;
  int          b2b_hs;
  int          last_hs;

  sum_of_squares_if #(.N(32)) bus();

  sum_of_squares #(.N(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: records acceptances, checks latency on out_valid rise and
  // pops/compares the scoreboard on every result handshake.
  always @(negedge clock) begin
    if (!reset && bus.in_valid && bus.in_ready)
      acc_q.push_back(cyc + 1);
    if (bus.out_valid && !prev_ov) begin
      if (acc_q.size() == 0) fail_now("latency_no_accept");
      else check("latency", 32'(cyc - acc_q.pop_front()), 32'd48);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) fail_now("unexpected_result");
      else check("sum_sq", bus.sum_sq, exp_q.pop_front());
      if (b2b_mode) begin
        if (b2b_hs > 0) check("b2b_spacing", 32'(cyc - last_hs), 32'd50);
        b2b_hs <= b2b_hs + 1;
      end
      last_hs <= cyc;
    end
    prev_ov <= bus.out_valid;
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic signed [15:0] x, input logic signed [15:0] y,
                      input logic signed [15:0] z, input logic [31:0] e,
                      input bit push, input bit hold_valid);
    bit ok;
    if (push) exp_q.push_back(e);
    bus.dx = x;
    bus.dy = y;
    bus.dz = z;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clock);
      ok = bus.in_ready;
    end
    if (!ok) fail_now("accept_timeout");
    @(posedge clock);
    #1;
    if (!hold_valid) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(negedge clock);
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    prev_ov = 1'b0;
    b2b_mode = 1'b0;
    b2b_hs = 0;
    last_hs = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.dx = '0;
    bus.dy = '0;
    bus.dz = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_sum_sq", bus.sum_sq, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1;

    send(16'sd3, 16'sd4, 16'sd0, 32'd25, 1, 0);             drain();
    send(-16'sd7, 16'sd2, -16'sd12, 32'd197, 1, 0);         drain();
    send(16'sd1, -16'sd1, 16'sd1, 32'd3, 1, 0);             drain();
    send(-16'sd32768, -16'sd32768, -16'sd32768, 32'hC000_0000, 1, 0); drain();
    send(16'sd32767, -16'sd32768, 16'sd0, 32'h7FFF_0001, 1, 0);       drain();
    send(16'sd0, 16'sd0, 16'sd0, 32'd0, 1, 0);              drain();

    // Backpressure: 100^2 + 50^2 + 25^2 = 13125
    bus.out_ready = 1'b0;
    send(16'sd100, 16'sd50, -16'sd25, 32'd13125, 1, 0);
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 100 && !seen; n++) begin
        @(negedge clock);
        seen = bus.out_valid;
      end
      if (!seen) fail_now("bp_valid_timeout");
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("bp_sum_sq", bus.sum_sq, 32'd13125);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clock);
      #1;
      bus.dx = 16'(i * 1234 - 7000);
      bus.dy = 16'(-i * 321);
      bus.dz = 16'(i * 77);
      bus.in_valid = i[0];
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset 10 cycles into SQ; the aborted triple must never produce a result.
    send(16'sd9, 16'sd9, 16'sd9, 32'd0, 0, 0);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    acc_q.delete();
    @(negedge clock);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_sum_sq", bus.sum_sq, 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1;
    send(16'sd5, 16'sd12, 16'sd0, 32'd169, 1, 0);           drain();

    // Back-to-back with in_valid held high and out_ready tied high.
    b2b_mode = 1'b1;
    send(16'sd100, -16'sd200, 16'sd300, 32'd140000, 1, 1);
    send(-16'sd1000, 16'sd2000, -16'sd3000, 32'd14000000, 1, 1);
    send(16'sd12345, 16'sd0, -16'sd1, 32'd152399026, 1, 1);
    send(-16'sd32768, 16'sd32767, 16'sd1, 32'd2147418114, 1, 0);
    drain();
    b2b_mode = 1'b0;
    check("b2b_count", 32'(b2b_hs), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sum_of_squares.md
# sum_of_squares

Sequential sum-of-squares unit that forms the radicand for `square_root`. It accepts one signed (dx, dy, dz) point-difference triple and computes dx² + dy² + dz² with a 1-bit-per-cycle shift-add multiplier shared across the three axes. It returns the N-bit unsigned result through a valid/ready handshake. It sits upstream of `square_root` in the LiDAR neighbour-distance path, and its output width matches that block's `num` input.

## Interface
- `N`, 32: result width; must be even and ≥ 8.
- `D`, N/2: signed input width per axis; fixed to N/2 so that the worst-case sum cannot overflow N bits.

- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  triple on dx/dy/dz is valid.
- `in_ready`  out  1  block can accept a triple.
- `dx`, `dy`, `dz`  in  D each  signed two's-complement axis differences.
- `out_valid`  out  1  `sum_sq` holds a completed result.
- `out_ready`  in  1  consumer accepts the result.
- `sum_sq`  out  N  unsigned dx² + dy² + dz².

## Operation
- The FSM has three states: IDLE, SQ and DONE. Reset forces IDLE.
- `in_ready` = (state == IDLE) && !reset. It is combinational from state.
- **IDLE, on `in_valid && in_ready`:**
  - Capture |dx|, |dy| and |dz| as D-bit unsigned values. |−2^(D−1)| = 2^(D−1) must be represented exactly, with no sign overflow.
  - Clear the N-bit accumulator, set axis = 0 and bit = 0, then enter SQ.
- **SQ, one iteration per cycle for the current axis magnitude m:**
  - The multiplicand register (N bits, initialised to zero-extended m) shifts left by 1 each cycle.
  - The multiplier register (D bits, initialised to m) shifts right by 1 each cycle.
  - If the multiplier LSB is 1, add the multiplicand to the accumulator (mod 2^N). No overflow occurs for legal inputs: the maximum sum is 3·2^(2D−2) < 2^N.
  - When bit == D−1, reload the multiplicand and multiplier from the next axis magnitude, set bit = 0 and increment axis.
  - After axis 2 completes its bit D−1, load `sum_sq` from the accumulator (including the final add), set `out_valid` = 1 and enter DONE.
- **DONE:**
  - `sum_sq` and `out_valid` hold steady until `out_valid && out_ready`.
  - On that edge, go to IDLE with `out_valid` = 0.
  - `sum_sq` retains its last value afterwards, until the next result or a reset.
- Inputs dx/dy/dz are ignored outside the accepting edge. Changing them mid-computation has no effect.
- `in_valid` while busy (SQ or DONE) is not accepted. The upstream block must hold it.

## Timing
- **Reset values:** state = IDLE, `out_valid` = 0, `sum_sq` = 0, accumulator = 0, counters = 0. `in_ready` = 0 while `reset` is high and 1 on the first cycle after it is released.
- **Latency:** if the triple is accepted on edge k, `out_valid` rises on edge k + 3·D (48 for D = 16). SQ occupies exactly 3·D cycles, independent of operand value. There is no early termination.
- **Throughput:**
  - The result handshake on edge j returns the FSM to IDLE. `in_ready` becomes 1 in the cycle after edge j, so the earliest next acceptance is edge j+1. There is no same-cycle accept/complete bypass.
  - With `out_ready` tied high, one result is produced per 3·D + 2 cycles.
- **Backpressure:** with `out_ready` = 0, the block remains in DONE indefinitely with `out_valid` = 1 and `sum_sq` stable. `in_ready` stays 0.
- **Reset mid-operation** (in SQ or DONE): the computation is aborted, `out_valid` drops to 0 on the reset edge, and no partial result is ever presented.
- **Reset and handshake on the same edge:** reset wins, and the result is discarded.

## Test plan
- Accept (dx, dy, dz) = (3, 4, 0). Required: `sum_sq` = 25 with `out_valid` rising exactly 48 edges after acceptance. Also (−7, 2, −12) → 197, and (1, −1, 1) → 3.
- Apply the extremes (−32768, −32768, −32768). Required: `sum_sq` = 0xC000_0000. Apply (32767, −32768, 0). Required: 0x7FFF_0001.
- Apply (0, 0, 0). Required: `sum_sq` = 0 with the same 48-cycle latency.
- **Backpressure:**
  - Hold `out_ready` = 0 for 20 cycles after `out_valid` rises. Required: `sum_sq` stable and `in_ready` = 0 throughout.
  - Toggle dx/dy/dz and pulse `in_valid` during this window. Required: no effect on the result.
- **Reset mid-operation:** assert `reset` for 1 cycle, 10 cycles into SQ. Required: `out_valid` stays 0, `sum_sq` = 0, and `in_ready` = 1 the next cycle. A new triple (5, 12, 0) then yields 169 after 48 edges.
- **Back-to-back operation:** drive 4 random triples with `in_valid` held high and `out_ready` = 1. Required: results match the reference model in order, spaced 50 cycles apart, with no triple lost or duplicated.
